// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file debug dumper: default sizes matching
// the CPU register file and the dump FSM state encoding.
package reg_dump_pkg;

  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage

// File: rtl/reg_dump_if.sv
// Bundles the spare register-file read port and the (address, data) output stream.
// Stream handshake: a word transfers on a rising edge where out_valid && out_ready; once
// out_valid is high, out_addr/out_data/out_last hold stable until that edge; out_ready
// carries no meaning while out_valid is low.
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic [AW-1:0] R_addr;
  logic [DW-1:0] R_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output R_addr,
    input  R_data,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data,
    output out_last
  );

  modport slave (
    input  R_addr,
    output R_data,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/reg_dump.sv
// Walks register addresses 0..NREGS-1 through one read port and streams each
// captured word out as an (address, data) pair; never writes the register file.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output state_t     dbg_state_o,
  reg_dump_if.master dump
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Each word is sampled in its own READ cycle, so register writes landing
  // before that cycle show up in the dump and later ones do not.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        out_data_d  = dump.R_data;
        out_addr_d  = idx_q;
        out_last_d  = (idx_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_valid_q && dump.out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dump.R_addr    = (state_q == ST_IDLE) ? '0 : idx_q;
  assign dump.out_valid = out_valid_q;
  assign dump.out_addr  = out_addr_q;
  assign dump.out_data  = out_data_q;
  assign dump.out_last  = out_last_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: randomized register contents and sink
// backpressure checked against a cycle-timeline model of the dump.
module tb_reg_dump;
  import reg_dump_pkg::*;

  localparam int NR = NREGS_DEF;
  localparam int W  = AW_DEF + DW_DEF;

  // clock / reset
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  state_t dbg_state;
  logic [DW_DEF-1:0] rf [NR];

  always #5 clk = ~clk;

  reg_dump_if #(.AW(AW_DEF), .DW(DW_DEF)) dut_if ();

  reg_dump #(.NREGS(NR), .AW(AW_DEF), .DW(DW_DEF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state),
    .dump       (dut_if)
  );

  assign dut_if.R_data = rf[dut_if.R_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: timeline of the current dump plus scoreboard of sampled words
  int               cyc = 0;
  logic             m_active = 1'b0;
  int               m_word = 0;
  int               m_valid_cyc = 0;
  logic [W-1:0]     exp_q[$];
  logic             e_valid, e_busy, e_done, e_last;
  logic [AW_DEF-1:0] e_addr, e_raddr;
  logic [DW_DEF-1:0] e_data;

  task automatic fill_rf(input bit rnd);
    for (int i = 0; i < NR; i++) rf[i] = rnd ? $urandom : '0;
    rf[0] = '0;
  endtask

  // driver: apply inputs for the current cycle, advance the model, move to next cycle
  task automatic cycle(input logic st, input logic rdy, input logic r);
    logic cur_valid;
    logic nxt_done;
    start = st;
    dut_if.out_ready = rdy;
    rst = r;
    cur_valid = m_active && (cyc >= m_valid_cyc);
    if (m_active && (cyc == m_valid_cyc - 1))
      exp_q.push_back({AW_DEF'(m_word), rf[m_word]});
    nxt_done = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_word = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_word = 0;
        m_valid_cyc = cyc + 2;
      end
    end else if (cur_valid && rdy) begin
      void'(exp_q.pop_front());
      if (m_word == NR - 1) begin
        m_active = 1'b0;
        nxt_done = 1'b1;
      end else begin
        m_word++;
        m_valid_cyc = cyc + 2;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    e_done  = nxt_done;
    e_busy  = m_active;
    e_valid = m_active && (cyc >= m_valid_cyc);
    e_raddr = m_active ? AW_DEF'(m_word) : '0;
    e_addr  = '0;
    e_data  = '0;
    if (e_valid && exp_q.size() > 0) {e_addr, e_data} = exp_q[0];
    e_last = (e_addr == AW_DEF'(NR - 1));
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    n_checks += 8;
    if (dut_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", dut_if.out_valid); end
    if (dut_if.out_addr !== '0) begin n_fail++; $display("FAIL rst_addr got=%0d exp=0", dut_if.out_addr); end
    if (dut_if.out_data !== '0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", dut_if.out_data); end
    if (dut_if.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got=%b exp=0", dut_if.out_last); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
    if (dut_if.R_addr !== '0) begin n_fail++; $display("FAIL rst_raddr got=%0d exp=0", dut_if.R_addr); end
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full_dump();
    int s, words, dones, done_cyc;
    logic [DW_DEF-1:0] want;
    fill_rf(1'b0);
    rf[29] = 32'd16384;
    words = 0; dones = 0; done_cyc = -1;
    s = cyc;
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 70; k++) begin
      n_checks += 4;
      if (dut_if.out_valid !== e_valid) begin n_fail++; $display("FAIL full_valid cyc=%0d got=%b exp=%b", cyc, dut_if.out_valid, e_valid); end
      if (busy !== e_busy) begin n_fail++; $display("FAIL full_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (done !== e_done) begin n_fail++; $display("FAIL full_done cyc=%0d got=%b exp=%b", cyc, done, e_done); end
      if (dut_if.R_addr !== e_raddr) begin n_fail++; $display("FAIL full_raddr cyc=%0d got=%0d exp=%0d", cyc, dut_if.R_addr, e_raddr); end
      if (e_valid) begin
        n_checks += 3;
        if (dut_if.out_addr !== e_addr) begin n_fail++; $display("FAIL full_addr cyc=%0d got=%0d exp=%0d", cyc, dut_if.out_addr, e_addr); end
        if (dut_if.out_data !== e_data) begin n_fail++; $display("FAIL full_data cyc=%0d got=%h exp=%h", cyc, dut_if.out_data, e_data); end
        if (dut_if.out_last !== e_last) begin n_fail++; $display("FAIL full_last cyc=%0d got=%b exp=%b", cyc, dut_if.out_last, e_last); end
      end
      if (dut_if.out_valid === 1'b1) begin
        words++;
        want = (dut_if.out_addr == 29) ? 32'd16384 : 32'd0;
        n_checks += 2;
        if ((cyc - s - 2) != 2 * int'(dut_if.out_addr)) begin n_fail++; $display("FAIL full_word_time addr=%0d got_cyc=%0d exp_cyc=%0d", dut_if.out_addr, cyc - s, 2 + 2 * int'(dut_if.out_addr)); end
        if (dut_if.out_data !== want) begin n_fail++; $display("FAIL full_word_value addr=%0d got=%h exp=%h", dut_if.out_addr, dut_if.out_data, want); end
      end
      if (done === 1'b1) begin dones++; done_cyc = cyc - s; end
      cycle(1'b0, 1'b1, 1'b0);
    end
    n_checks += 4;
    if (words != NR) begin n_fail++; $display("FAIL full_word_count got=%0d exp=%0d", words, NR); end
    if (dones != 1) begin n_fail++; $display("FAIL full_done_count got=%0d exp=1", dones); end
    if (done_cyc != 65) begin n_fail++; $display("FAIL full_done_time got=%0d exp=65", done_cyc); end
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL full_end_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_backpressure();
    int hold;
    logic rdy;
    fill_rf(1'b1);
    hold = 0;
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      if (!m_active && k > 2) break;
      n_checks += 3;
      if (dut_if.out_valid !== e_valid) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, dut_if.out_valid, e_valid); end
      if (busy !== e_busy) begin n_fail++; $display("FAIL bp_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (done !== e_done) begin n_fail++; $display("FAIL bp_done cyc=%0d got=%b exp=%b", cyc, done, e_done); end
      if (e_valid) begin
        n_checks += 3;
        if (dut_if.out_addr !== e_addr) begin n_fail++; $display("FAIL bp_addr cyc=%0d got=%0d exp=%0d", cyc, dut_if.out_addr, e_addr); end
        if (dut_if.out_data !== e_data) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, dut_if.out_data, e_data); end
        if (dut_if.out_last !== e_last) begin n_fail++; $display("FAIL bp_last cyc=%0d got=%b exp=%b", cyc, dut_if.out_last, e_last); end
      end
      if (e_valid && e_addr == 3 && hold < 5) begin
        rdy = 1'b0;
        hold++;
      end else if (e_addr > 8) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      cycle(1'b0, rdy, 1'b0);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_finish busy got=%b exp=0", busy); end
  endtask

  task automatic test_rf_writes();
    int s;
    bit wrote6;
    fill_rf(1'b0);
    wrote6 = 0;
    s = cyc;
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 70; k++) begin
      n_checks++;
      if (dut_if.out_valid !== e_valid) begin n_fail++; $display("FAIL wr_valid cyc=%0d got=%b exp=%b", cyc, dut_if.out_valid, e_valid); end
      if (e_valid) begin
        n_checks++;
        if (dut_if.out_data !== e_data) begin n_fail++; $display("FAIL wr_data cyc=%0d got=%h exp=%h", cyc, dut_if.out_data, e_data); end
        if (e_addr == 5) begin
          n_checks++;
          if (dut_if.out_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_r5 got=%h exp=deadbeef", dut_if.out_data); end
        end
        if (e_addr == 6) begin
          n_checks++;
          if (dut_if.out_data !== 32'h0) begin n_fail++; $display("FAIL wr_r6 got=%h exp=00000000", dut_if.out_data); end
        end
      end
      if (cyc == s + 5) rf[5] = 32'hDEADBEEF;
      if (e_valid && e_addr == 6 && !wrote6) begin
        rf[6] = 32'h12345678;
        wrote6 = 1;
      end
      cycle(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    logic st;
    fill_rf(1'b1);
    dones = 0;
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 75; k++) begin
      n_checks += 3;
      if (dut_if.out_valid !== e_valid) begin n_fail++; $display("FAIL ign_valid cyc=%0d got=%b exp=%b", cyc, dut_if.out_valid, e_valid); end
      if (busy !== e_busy) begin n_fail++; $display("FAIL ign_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (done !== e_done) begin n_fail++; $display("FAIL ign_done cyc=%0d got=%b exp=%b", cyc, done, e_done); end
      if (e_valid) begin
        n_checks += 2;
        if (dut_if.out_addr !== e_addr) begin n_fail++; $display("FAIL ign_addr cyc=%0d got=%0d exp=%0d", cyc, dut_if.out_addr, e_addr); end
        if (dut_if.out_data !== e_data) begin n_fail++; $display("FAIL ign_data cyc=%0d got=%h exp=%h", cyc, dut_if.out_data, e_data); end
      end
      if (done === 1'b1) dones++;
      st = e_valid && (e_addr == 10);
      cycle(st, 1'b1, 1'b0);
    end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_reset_mid();
    int words, first_addr;
    fill_rf(1'b1);
    rf[15] = 32'hA5A5_0F0F;
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (e_valid && e_addr == 15) begin
        cycle(1'b0, 1'b1, 1'b1);
        break;
      end
      cycle(1'b0, 1'b1, 1'b0);
    end
    n_checks += 6;
    if (dut_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", dut_if.out_valid); end
    if (dut_if.out_addr !== '0) begin n_fail++; $display("FAIL mid_rst_addr got=%0d exp=0", dut_if.out_addr); end
    if (dut_if.out_data !== '0) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=0", dut_if.out_data); end
    if (dut_if.out_last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_last got=%b exp=0", dut_if.out_last); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    if (dut_if.R_addr !== '0) begin n_fail++; $display("FAIL mid_rst_raddr got=%0d exp=0", dut_if.R_addr); end
    cycle(1'b0, 1'b0, 1'b0);
    words = 0;
    first_addr = -1;
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 70; k++) begin
      n_checks += 2;
      if (dut_if.out_valid !== e_valid) begin n_fail++; $display("FAIL mid_valid cyc=%0d got=%b exp=%b", cyc, dut_if.out_valid, e_valid); end
      if (busy !== e_busy) begin n_fail++; $display("FAIL mid_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (e_valid) begin
        n_checks += 2;
        if (dut_if.out_addr !== e_addr) begin n_fail++; $display("FAIL mid_addr cyc=%0d got=%0d exp=%0d", cyc, dut_if.out_addr, e_addr); end
        if (dut_if.out_data !== e_data) begin n_fail++; $display("FAIL mid_data cyc=%0d got=%h exp=%h", cyc, dut_if.out_data, e_data); end
      end
      if (dut_if.out_valid === 1'b1) begin
        if (first_addr < 0) first_addr = int'(dut_if.out_addr);
        words++;
      end
      cycle(1'b0, 1'b1, 1'b0);
    end
    n_checks += 2;
    if (first_addr != 0) begin n_fail++; $display("FAIL mid_first_addr got=%0d exp=0", first_addr); end
    if (words != NR) begin n_fail++; $display("FAIL mid_word_count got=%0d exp=%0d", words, NR); end
  endtask

  task automatic test_back_to_back();
    int dones;
    logic prev_done;
    fill_rf(1'b1);
    dones = 0;
    prev_done = 1'b0;
    for (int k = 0; k < 135; k++) begin
      n_checks += 3;
      if (done !== e_done) begin n_fail++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", cyc, done, e_done); end
      if (busy !== e_busy) begin n_fail++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (dut_if.R_addr !== e_raddr) begin n_fail++; $display("FAIL b2b_raddr cyc=%0d got=%0d exp=%0d", cyc, dut_if.R_addr, e_raddr); end
      if (e_valid) begin
        n_checks += 2;
        if (dut_if.out_addr !== e_addr) begin n_fail++; $display("FAIL b2b_addr cyc=%0d got=%0d exp=%0d", cyc, dut_if.out_addr, e_addr); end
        if (dut_if.out_data !== e_data) begin n_fail++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, dut_if.out_data, e_data); end
      end
      if (prev_done) begin
        n_checks += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy cyc=%0d got=%b exp=1", cyc, busy); end
        if (dut_if.R_addr !== '0) begin n_fail++; $display("FAIL b2b_restart_raddr cyc=%0d got=%0d exp=0", cyc, dut_if.R_addr); end
      end
      if (done === 1'b1) dones++;
      prev_done = e_done;
      cycle(1'b1, 1'b1, 1'b0);
    end
    n_checks++;
    if (dones != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    for (int k = 0; k < 80; k++) begin
      if (!m_active) break;
      cycle(1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain busy got=%b exp=0", busy); end
  endtask

  initial begin
    dut_if.out_ready = 1'b0;
    fill_rf(1'b0);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_rf_writes();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug reader for the CPU register file. On a start pulse it walks register addresses 0..NREGS-1 through one register-file read port, captures each word and streams it out as an (address, data) pair over a valid/ready handshake. It sits beside the register file on a spare read port and feeds a debug sink such as a UART transmitter or an on-screen register view. It does not write the register file.

## Interface
- NREGS, 32, registers dumped (addresses 0..NREGS-1)
- AW, 5, register address width
- DW, 32, register data width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin dump; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- R_addr  out  AW  read address to register-file port
- R_data  in  DW  combinational read data for R_addr
- out_valid  out  1  out_addr/out_data/out_last valid
- out_ready  in  1  sink accepts word when high with out_valid
- out_addr  out  AW  register index of current word
- out_data  out  DW  captured register value
- out_last  out  1  high with the word for index NREGS-1
- done  out  1  one-cycle pulse after last word accepted

## Operation
- States: IDLE, READ, SEND.
- IDLE: R_addr=0, out_valid=0. start=1 -> idx<=0, go READ.
- READ: R_addr=idx; at clock edge out_data<=R_data, out_addr<=idx, out_last<=(idx==NREGS-1), out_valid<=1, go SEND.
- SEND: hold out_* stable while out_valid && !out_ready. On handshake (out_valid && out_ready):
  - idx==NREGS-1 -> out_valid<=0, done<=1, go IDLE.
  - else idx<=idx+1, out_valid<=0, go READ.
- R_addr in SEND holds idx; no register-file requirement depends on it.
- start while busy: ignored, no restart, no queued request.
- No snapshot: each word is the register value in that word's READ cycle. Writes to a register before its READ cycle are visible; later writes are not.
- Index 0 is read through the port like any other (register file returns 0).
- idx counter is AW bits; NREGS must be <= 2^AW; no wrap occurs because the dump stops at NREGS-1.

## Timing
- Reset (rst=1 at edge): state=IDLE, idx=0, R_addr=0, busy=0, out_valid=0, out_addr=0, out_data=0, out_last=0, done=0. Reset mid-dump aborts immediately; the partially sent dump is not resumed.
- start high at edge t: cycle t+1 READ (busy=1, R_addr=0); cycle t+2 out_valid=1, out_addr=0.
- Throughput with out_ready held high: one word per 2 cycles. Word i is valid in cycle t+2+2i.
- Last handshake at cycle k: cycle k+1 done=1, busy=0, state IDLE. start sampled high in cycle k+1 begins a new dump (done and start coexist).
- done is registered and held for exactly one cycle.
- out_ready is ignored while out_valid=0.

## Structure
- Shared package (debug/CPU package): state encoding constants (IDLE, READ, SEND), default NREGS/AW/DW matching the register file.
- Single module with no sub-module: one FSM, one index counter, output registers.

## Test plan
- Reset register file (r29=16384, others 0); pulse start with out_ready=1 -> 32 words, out_addr 0..31 in order, out_data=0 except addr 29=16384, out_last only on addr 31, word i valid at t+2+2i, done pulse at t+65.
- Backpressure: out_ready=0 for 5 cycles on word 3 -> out_valid, out_addr=3 and out_data stay constant throughout; word 4 appears 2 cycles after the accepting edge.
- Write r5=0xDEADBEEF before index 5 is read -> dumped value 0xDEADBEEF. Write r6=0x12345678 while word 6 is in SEND -> dumped value is the pre-write 0.
- Pulse start again mid-dump at word 10 -> no restart; sequence continues 11..31, single done pulse.
- Assert rst during word 15 SEND -> next cycle all outputs 0, busy=0. A new start then yields a full dump from addr 0.
- start held high continuously -> back-to-back dumps; the second READ of addr 0 is in the cycle after done.
